// File: rtl/fro_sampler.sv
// Free-running-oscillator entropy sampler: synchronises NUM_RO async rings, XOR-folds and
// decimates them into raw bits, packs WORD_W-bit words onto valid/ready, and guards stuck entropy.
module fro_sampler #(
  parameter int NUM_RO    = 4,
  parameter int WORD_W    = 32,
  parameter int DECIM     = 1,
  parameter int REP_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [WORD_W-1:0] word_out,
  output logic              valid,
  input  logic              ready,
  output logic              overrun,
  output logic              fault
);
  localparam int BW = $clog2(WORD_W);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WORD_W - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

  typedef enum logic [1:0] {S_FILL, S_FULL, S_FAULT} state_e;

  state_e            state_q, state_d;
  logic [NUM_RO-1:0] sync1_q, sync2_q;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic              last_q, last_d;
  logic              ovr_q, ovr_d;
  logic              raw_bit, samp, wdone, trip;

  // Two-flop synchronisers; deliberately outside the reach of clr.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw_bit = ^sync2_q;

  // Sampling datapath: decimation, shift register, word counter, repetition test.
  always_comb begin
    samp    = en && (dcnt_q == DCNT_LAST);
    dcnt_d  = dcnt_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    rep_d   = rep_q;
    wdone   = 1'b0;
    if (en) dcnt_d = samp ? '0 : dcnt_q + DW'(1);
    if (samp) begin
      shreg_d = {shreg_q[WORD_W-2:0], raw_bit};
      wdone   = (bcnt_q == BCNT_LAST);
      bcnt_d  = wdone ? '0 : bcnt_q + BW'(1);
      last_d  = raw_bit;
      // rep_q==0 marks the first sample since reset/clr, so last_q is meaningless there
      if ((rep_q != '0) && (raw_bit == last_q))
        rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + RW'(1);
      else
        rep_d = RW'(1);
    end
    trip = samp && (rep_d == REP_MAX);
    if (clr) begin
      dcnt_d  = '0;
      shreg_d = '0;
      bcnt_d  = '0;
      last_d  = 1'b0;
      rep_d   = '0;
      wdone   = 1'b0;
      trip    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_FILL: begin
        if (wdone) begin
          state_d = S_FULL;
          word_d  = shreg_d;
        end
      end
      S_FULL: begin
        if (ready) begin
          if (wdone) word_d = shreg_d;
          else       state_d = S_FILL;
        end else if (wdone) begin
          ovr_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A trip suppresses whatever the word path decided on the same edge.
    if (trip) begin
      state_d = S_FAULT;
      word_d  = '0;
      ovr_d   = ovr_q;
    end
    if (clr) begin
      state_d = S_FILL;
      word_d  = '0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_FILL;
      shreg_q <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      rep_q   <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign word_out = word_q;
  assign valid    = (state_q == S_FULL);
  assign fault    = (state_q == S_FAULT);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_fro_sampler.sv
// Bench for fro_sampler: directed ring patterns, scoreboard of expected words popped on handshakes.
module tb_fro_sampler;
  logic       clk = 1'b0;
  logic       rst_b, en, en3, clr, ready;
  logic [3:0] ro_in;
  logic [7:0] word_out, word3;
  logic       valid, overrun, fault;
  logic       valid3, overrun3, fault3;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fro_sampler #(.NUM_RO(4), .WORD_W(8), .DECIM(1), .REP_LIMIT(16)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .ro_in(ro_in),
    .word_out(word_out), .valid(valid), .ready(ready), .overrun(overrun), .fault(fault)
  );

  fro_sampler #(.NUM_RO(4), .WORD_W(8), .DECIM(3), .REP_LIMIT(16)) dut3 (
    .clk(clk), .rst_b(rst_b), .en(en3), .clr(clr), .ro_in(ro_in),
    .word_out(word3), .valid(valid3), .ready(ready), .overrun(overrun3), .fault(fault3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Raw stream bit n, MSB first; the sample taken in iteration n+2 captures it.
  function automatic logic sbit(input logic [31:0] s, input int n);
    return (n < 32) ? s[31-n] : 1'b0;
  endfunction

  task automatic do_clr();
    clr = 1'b1; en = 1'b0; en3 = 1'b0; ready = 1'b0;
    tick();
    clr = 1'b0;
    chk("clr outputs", {valid, fault, overrun, word_out, valid3, fault3, overrun3, word3}, 0);
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_b && valid && ready) begin
        if (exp_q.size() == 0) chk("unexpected word", {24'h0, word_out}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("word", word_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    logic        bad;
    rst_b = 1'b0; en = 1'b0; en3 = 1'b0; clr = 1'b0; ready = 1'b0; ro_in = '0;
    tick(); tick();
    chk("reset outputs", {valid, fault, overrun, word_out}, 0);
    rst_b = 1'b1;
    tick();

    // Alternating ring, always ready: every word 8'h55.
    do_clr();
    s = 32'h5555_5555;
    repeat (3) exp_q.push_back(8'h55);
    for (int n = 0; n < 28; n++) begin
      ro_in = {3'b0, sbit(s, n)}; en = (n >= 2); ready = 1'b1;
      tick();
      if (n == 8) chk("t1 valid before 8th sample", valid, 0);
      if (n == 9) chk("t1 valid at 8th sample", valid, 1);
    end
    chk("t1 flags", {overrun, fault}, 0);
    chk("t1 drained", exp_q.size(), 0);

    // Backpressure: second word dropped, held word stays, one handshake.
    do_clr();
    s = 32'hA53C_C300; bad = 1'b0;
    exp_q.push_back(8'hA5);
    for (int n = 0; n < 30; n++) begin
      ro_in = {3'b0, sbit(s, n)}; en = (n >= 2); ready = (n == 22);
      tick();
      if (n == 9)  chk("t2 first word", {valid, word_out}, {1'b1, 8'hA5});
      if (n >= 9 && n < 22 && word_out != 8'hA5) bad = 1'b1;
      if (n == 16) chk("t2 overrun before drop", overrun, 0);
      if (n == 17) chk("t2 overrun on dropped word", {overrun, valid}, 2'b11);
      if (n == 22) chk("t2 valid after handshake", valid, 0);
      if (n == 24) chk("t2 idle before next word", valid, 0);
      if (n == 25) chk("t2 next word", {valid, word_out}, {1'b1, 8'hC3});
    end
    chk("t2 held word stable", bad, 0);
    chk("t2 overrun sticky", overrun, 1);
    chk("t2 drained", exp_q.size(), 0);

    // Handshake on the same edge a new word completes.
    do_clr();
    s = 32'h1234_0000;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    for (int n = 0; n < 21; n++) begin
      ro_in = {3'b0, sbit(s, n)}; en = (n >= 2); ready = (n == 17 || n == 19);
      tick();
      if (n == 17) chk("t6 back-to-back word", {valid, overrun, word_out}, {2'b10, 8'h34});
      if (n == 19) chk("t6 back to fill", valid, 0);
    end
    chk("t6 drained", exp_q.size(), 0);

    // Stuck rings: zero word, then fault on the 16th identical sample.
    do_clr();
    bad = 1'b0;
    for (int n = 0; n < 34; n++) begin
      ro_in = 4'b0000; en = (n >= 2); ready = (n >= 18);
      tick();
      if (n == 9)  chk("t3 zero word", {valid, word_out}, {1'b1, 8'h00});
      if (n == 16) chk("t3 no fault at 15 repeats", fault, 0);
      if (n == 17) chk("t3 fault at 16 repeats", {fault, valid, word_out}, {2'b10, 8'h00});
      if (n >= 18 && valid) bad = 1'b1;
    end
    chk("t3 frozen while faulted", {bad, fault}, 2'b01);
    do_clr();
    for (int n = 0; n < 10; n++) begin
      ro_in = 4'b0000; en = (n >= 2); ready = 1'b0;
      tick();
      if (n == 8) chk("t3 refill not early", {valid, fault}, 0);
      if (n == 9) chk("t3 refill word", {valid, word_out}, {1'b1, 8'h00});
    end

    // DECIM=3: 24 enabled cycles per word; a 5-cycle en gap delays it by 5.
    do_clr();
    for (int n = 0; n < 28; n++) begin
      ro_in = 4'b0001; en3 = (n >= 2);
      tick();
      if (n == 24) chk("t4 decim valid early", valid3, 0);
      if (n == 25) chk("t4 decim word", {valid3, word3}, {1'b1, 8'hFF});
    end
    chk("t4 decim flags", {fault3, overrun3}, 0);
    do_clr();
    for (int n = 0; n < 33; n++) begin
      ro_in = 4'b0001; en3 = (n >= 2) && !(n >= 10 && n < 15);
      tick();
      if (n == 29) chk("t4 paused valid early", valid3, 0);
      if (n == 30) chk("t4 paused word", {valid3, word3}, {1'b1, 8'hFF});
    end

    // Async reset mid-word while a word is pending.
    do_clr();
    s = 32'h5555_5555;
    for (int n = 0; n < 13; n++) begin
      ro_in = {3'b0, sbit(s, n)}; en = (n >= 2); ready = 1'b0;
      tick();
      if (n == 9) chk("t5 valid before reset", valid, 1);
    end
    #2 rst_b = 1'b0;
    #1 chk("t5 async reset", {valid, fault, overrun, word_out}, 0);
    tick(); tick();
    rst_b = 1'b1;
    for (int n = 0; n < 10; n++) begin
      ro_in = {3'b0, sbit(s, n)}; en = (n >= 2); ready = 1'b0;
      tick();
      if (n == 8) chk("t5 refill not early", valid, 0);
      if (n == 9) chk("t5 refill word", {valid, word_out}, {1'b1, 8'h55});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
